// File: rtl/data_mem_ctrl.sv
// Load/store controller between an RV32I core and a word-addressed data memory.
// Handles byte/half/word loads with sign/zero extension, word stores directly,
// and byte/half stores via a read-modify-write of the containing word.
module data_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5,
    ERR    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merged_q, merged_d;

  logic        req_illegal;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  // Classify the incoming request: bad width code or misaligned address.
  always_comb begin
    req_illegal = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_illegal = 1'b1;
    end else begin
      if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) req_illegal = 1'b1;
    end
    if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_illegal = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00) req_illegal = 1'b1;
  end

  // Lane extraction with extension for loads, and lane merge for sub-word stores.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3_q[1:0])
      2'd0:    load_data = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
      2'd1:    load_data = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase

    merged_word = mem_rdata;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
      else           merged_word[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged_word[7:0]   = wdata_q[7:0];
        2'd1:    merged_word[15:8]  = wdata_q[7:0];
        2'd2:    merged_word[23:16] = wdata_q[7:0];
        default: merged_word[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_illegal) begin
            state_d = ERR;
            rdata_d = '0;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3 == 3'd2) begin
            state_d = STORE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rdata_d = load_data;
        state_d = RESP;
      end
      STORE: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RMW_RD: begin
        merged_d = merged_word;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
    end
  end

  // Handshake, response and memory-port outputs; strobes are suppressed during reset.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP) || (state_q == ERR);
    resp_err   = (state_q == ERR);
    resp_rdata = rdata_q;
    mem_read   = !rst && ((state_q == LOAD) || (state_q == RMW_RD));
    mem_write  = !rst && ((state_q == STORE) || (state_q == RMW_WR));
    mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : '0;
    if (mem_write) mem_wdata = (state_q == STORE) ? wdata_q : merged_q;
    else           mem_wdata = '0;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a small word-addressed memory model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:15];
  logic        mem_init;

  int checks   = 0;
  int failures = 0;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
      mem[1] <= 32'h11223344;
      mem[2] <= 32'h8000FF80;
      mem[3] <= 32'hDEADBEEF;
    end else if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          reads;
    int          writes;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    int          reads;
    int          writes;
    int          both;
    int          badaddr;
    logic [31:0] r_rdata;
    logic        r_err;
    lat = 0; reads = 0; writes = 0; both = 0; badaddr = 0;
    r_rdata = 'x; r_err = 1'bx;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_read)  reads++;
      if (mem_write) writes++;
      if (mem_read && mem_write) both++;
      if ((mem_read || mem_write) && mem_addr !== {v.addr[31:2], 2'b00}) badaddr++;
      if (resp_valid) begin
        lat     = k;
        r_rdata = resp_rdata;
        r_err   = resp_err;
        break;
      end
    end
    check({tag, ".lat"},     lat,        v.lat);
    check({tag, ".err"},     {31'd0, r_err}, {31'd0, v.err});
    check({tag, ".rdata"},   r_rdata,    v.rdata);
    check({tag, ".reads"},   reads,      v.reads);
    check({tag, ".writes"},  writes,     v.writes);
    check({tag, ".both"},    both,       0);
    check({tag, ".addr"},    badaddr,    0);
    @(negedge clk);
    check({tag, ".pulse"},   {31'd0, resp_valid}, 32'd0);
    check({tag, ".errlow"},  {31'd0, resp_err},   32'd0);
    if (v.midx >= 0) check({tag, ".mem"}, mem[v.midx], v.mval);
  endtask

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          resp_cnt;
    int          k_first;
    int          k_second;
    int          ready_bad;
    logic [31:0] second_rdata;
    logic        first_err;
    logic        second_err;

    //           we  f3    addr          wdata          lat err rdata          rd wr midx mval
    vecs[0]  = '{1'b0, 3'd0, 32'h00000007, 32'h00000000, 2, 1'b0, 32'h00000011, 1, 0, -1, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h00000004, 32'h00000000, 2, 1'b0, 32'h00000044, 1, 0, -1, 32'h0};
    vecs[2]  = '{1'b0, 3'd1, 32'h0000000A, 32'h00000000, 2, 1'b0, 32'hFFFF8000, 1, 0, -1, 32'h0};
    vecs[3]  = '{1'b0, 3'd5, 32'h0000000A, 32'h00000000, 2, 1'b0, 32'h00008000, 1, 0, -1, 32'h0};
    vecs[4]  = '{1'b0, 3'd0, 32'h00000008, 32'h00000000, 2, 1'b0, 32'hFFFFFF80, 1, 0, -1, 32'h0};
    vecs[5]  = '{1'b0, 3'd4, 32'h00000009, 32'h00000000, 2, 1'b0, 32'h000000FF, 1, 0, -1, 32'h0};
    vecs[6]  = '{1'b0, 3'd2, 32'h00000008, 32'h00000000, 2, 1'b0, 32'h8000FF80, 1, 0, -1, 32'h0};
    vecs[7]  = '{1'b0, 3'd2, 32'h00000006, 32'h00000000, 1, 1'b1, 32'h00000000, 0, 0, -1, 32'h0};
    vecs[8]  = '{1'b1, 3'd1, 32'h00000003, 32'h0000FFFF, 1, 1'b1, 32'h00000000, 0, 0,  0, 32'h0};
    vecs[9]  = '{1'b1, 3'd4, 32'h00000004, 32'hFFFFFFFF, 1, 1'b1, 32'h00000000, 0, 0,  1, 32'h11223344};
    vecs[10] = '{1'b0, 3'd3, 32'h00000004, 32'h00000000, 1, 1'b1, 32'h00000000, 0, 0, -1, 32'h0};
    vecs[11] = '{1'b1, 3'd0, 32'h00000005, 32'hAABBCCDD, 3, 1'b0, 32'h00000000, 1, 1,  1, 32'h1122DD44};
    vecs[12] = '{1'b0, 3'd2, 32'h00000004, 32'h00000000, 2, 1'b0, 32'h1122DD44, 1, 0, -1, 32'h0};
    vecs[13] = '{1'b1, 3'd1, 32'h0000000E, 32'h1234BEEF, 3, 1'b0, 32'h00000000, 1, 1,  3, 32'hBEEFBEEF};
    vecs[14] = '{1'b1, 3'd2, 32'h0000000C, 32'hCAFEF00D, 2, 1'b0, 32'h00000000, 0, 1,  3, 32'hCAFEF00D};
    vecs[15] = '{1'b0, 3'd1, 32'h0000000C, 32'h00000000, 2, 1'b0, 32'hFFFFF00D, 1, 0, -1, 32'h0};
    vecs[16] = '{1'b0, 3'd5, 32'h00000005, 32'h00000000, 1, 1'b1, 32'h00000000, 0, 0, -1, 32'h0};

    rst        = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.resp_err",   {31'd0, resp_err},   32'd0);
    check("rst.resp_rdata", resp_rdata,          32'd0);
    check("rst.mem_read",   {31'd0, mem_read},   32'd0);
    check("rst.mem_write",  {31'd0, mem_write},  32'd0);
    check("rst.mem_addr",   mem_addr,            32'd0);
    mem_init = 1'b0;
    rst      = 1'b0;
    #1;
    check("rst.ready", {31'd0, req_ready}, 32'd1);

    for (int unsigned i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset during the write half of a half-word read-modify-write.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd1;
    req_addr   = 32'h00000004;
    req_wdata  = 32'h00005555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmwrst.rd", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    check("rmwrst.wr_pre", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rmwrst.wr_gated", {31'd0, mem_write}, 32'd0);
    check("rmwrst.rd_gated", {31'd0, mem_read},  32'd0);
    @(negedge clk);
    check("rmwrst.no_resp", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rmwrst.ready", {31'd0, req_ready}, 32'd1);
    check("rmwrst.mem",   mem[1],             32'h1122DD44);
    resp_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check("rmwrst.quiet", resp_cnt, 0);

    // Back-to-back SW then LW with req_valid held high.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h00000010;
    req_wdata  = 32'h0BADCAFE;
    @(posedge clk);
    resp_cnt = 0; k_first = 0; k_second = 0; ready_bad = 0;
    second_rdata = 'x; first_err = 1'bx; second_err = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((k == 1 || k == 2 || k == 4 || k == 5) && req_ready) ready_bad++;
      if (k == 3 && !req_ready) ready_bad++;
      if (resp_valid) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          k_first   = k;
          first_err = resp_err;
        end else if (resp_cnt == 2) begin
          k_second     = k;
          second_rdata = resp_rdata;
          second_err   = resp_err;
        end
      end
      if (k == 1) begin
        req_we     = 1'b0;
        req_wdata  = 32'h0;
      end
      if (k == 4) req_valid = 1'b0;
    end
    check("b2b.ready",       ready_bad, 0);
    check("b2b.resp_cnt",    resp_cnt,  2);
    check("b2b.first_k",     k_first,   2);
    check("b2b.first_err",   {31'd0, first_err},  32'd0);
    check("b2b.second_k",    k_second,  5);
    check("b2b.second_err",  {31'd0, second_err}, 32'd0);
    check("b2b.rdata",       second_rdata, 32'h0BADCAFE);
    check("b2b.mem",         mem[4],       32'h0BADCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 req_valid  in  1  core presents a load/store request.
REQ-004 req_ready  out  1  controller can accept a request (high only in IDLE).
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_funct3  in  3  RV32I width code: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (loads); 0 SB, 1 SH, 2 SW (stores).
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data; byte/half taken from low bits.
REQ-009 resp_valid  out  1  one-cycle pulse; request complete.
REQ-010 resp_rdata  out  32  extended load result; 0 for stores and errors; held between responses.
REQ-011 resp_err  out  1  valid with resp_valid; misaligned or illegal request.
REQ-012 mem_read  out  1  read strobe to word-addressed data memory.
REQ-013 mem_write  out  1  write strobe; memory writes on the clk edge where it is high.
REQ-014 mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 mem_wdata  out  32  full word to write.
REQ-016 mem_rdata  in  32  combinational read data, valid in the same cycle as mem_read.

Function
REQ-017 FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP, ERR.
REQ-018 IDLE: req_ready=1; on req_valid, latch we/funct3/addr/wdata at that edge (acceptance edge T).
REQ-019 Illegal: load funct3 in {3,6,7}; store funct3 > 2; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-020 Illegal request -> ERR: resp_valid=1, resp_err=1, resp_rdata=0, no mem strobe; next state IDLE (response 1 cycle after T).
REQ-021 Load -> LOAD: mem_read=1; select byte at addr[1:0] or half at addr[1]; sign-extend (LB/LH) or zero-extend (LBU/LHU); register into resp_rdata; -> RESP (response 2 cycles after T).
REQ-022 SW -> STORE: mem_write=1, mem_wdata=latched wdata; -> RESP (2 cycles after T).
REQ-023 SB/SH -> RMW_RD: mem_read=1; register merged word = mem_rdata with the target byte lane (addr[1:0]) or half lane (addr[1]) replaced by wdata[7:0]/[15:0]; -> RMW_WR: mem_write=1, mem_wdata=merged word; -> RESP (3 cycles after T).
REQ-024 RESP: resp_valid=1, resp_err=0; -> IDLE; a new request can be accepted in the following cycle.
REQ-025 req_ready=0 in all states except IDLE; req_valid outside IDLE is ignored.
REQ-026 mem_read and mem_write never high together; both 0 outside LOAD/STORE/RMW_RD/RMW_WR.
REQ-027 mem_addr and mem_wdata = 0 whenever both strobes are low; mem_wdata = 0 when mem_write is low.
REQ-028 mem_read and mem_write gated by !rst: no memory write in any cycle where rst=1.
REQ-029 resp_valid is high for exactly one cycle per accepted request; resp_err is 0 whenever resp_valid is 0.

Reset
REQ-030 rst=1 at an edge: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, latched request cleared; overrides all other transitions.
REQ-031 Reset mid RMW: interrupted SB/SH produces no response and no memory write (partial RMW abandoned, memory unchanged).
REQ-032 Out of reset: req_ready=1 in the first cycle with rst=0.

Verification
REQ-033 mem[1]=0x11223344; LB addr 0x7 -> resp 2 cycles after T, resp_rdata=0x00000011; LB addr 0x4 -> 0x00000044.
REQ-034 mem[2]=0x8000FF80; LH addr 0xA -> 0xFFFF8000; LHU addr 0xA -> 0x00008000; LB addr 0x8 -> 0xFFFFFF80.
REQ-035 mem[1]=0x11223344; SB addr 0x5 wdata 0xAABBCCDD -> mem_read then mem_write in consecutive cycles, mem_wdata=0x1122DD44, resp 3 cycles after T.
REQ-036 LW addr 0x6 -> ERR: resp_valid=1, resp_err=1, no mem strobe; SH addr 0x3 -> same; store funct3=4 -> same.
REQ-037 SH addr 0x4 accepted; rst=1 in RMW_WR cycle -> mem_write=0, mem[1] unchanged, no resp_valid, req_ready=1 after rst falls.
REQ-038 Back-to-back: req_valid held high with SW then LW same address -> second accepted cycle after RESP; LW returns stored value; req_ready low while busy.
